dequantizer_unpack: RTL

- Receive-side counterpart of the quantizer_N family: takes a stream of 32-bit words, each packed MSB-first with BITS-bit quantizer codes, and reconstructs one 32-bit sample per code.
- Reconstruction is either the exact quantizer output (code in the top bits, zeros below) or a mid-point value that halves the error.
- Sits between the packed-code channel and downstream error/SNR measurement logic.
- Valid/ready handshake on both sides.

---
 rtl/quant_pkg.sv | 28 ++
 rtl/dequant_recon.sv | 16 +
 rtl/dequantizer_unpack.sv | 117 +++++++++++
 3 files changed

// File: rtl/quant_pkg.sv
// Shared definitions for the quantizer / dequantizer family: word width,
// codes-per-word and reconstruction fill helpers.
package quant_pkg;

   localparam int WORD_W = 32;

   typedef enum logic {
      EMPTY = 1'b0,
      DRAIN = 1'b1
   } drain_state_e;

   // Only code widths that tile a word exactly are supported.
   function automatic bit bits_legal(input int bits);
      return (bits == 1) || (bits == 2) || (bits == 4) || (bits == 8) || (bits == 16);
   endfunction

   function automatic int cpw(input int bits);
      return WORD_W / bits;
   endfunction

   // Midpoint reconstruction sets the bit just below the code, halving the error.
   function automatic logic [WORD_W-1:0] recon_fill(input int bits, input bit midpoint);
      logic [WORD_W-1:0] one;
      one = 1;
      return midpoint ? (one << (WORD_W - 1 - bits)) : '0;
   endfunction

endpackage

// File: rtl/dequant_recon.sv
// Combinational code-to-sample reconstruction: code in the top bits, fill below.
module dequant_recon
   import quant_pkg::*;
#(
   parameter int BITS     = 4,
   parameter bit MIDPOINT = 1'b1
) (
   input  logic [BITS-1:0]   code,
   output logic [WORD_W-1:0] sample
);

   localparam logic [WORD_W-1:0] FILL = recon_fill(BITS, MIDPOINT);

   assign sample = {code, {(WORD_W-BITS){1'b0}}} | FILL;

endmodule

// File: rtl/dequantizer_unpack.sv
// Unpacks 32-bit words of MSB-first BITS-wide codes into one reconstructed
// sample per code, with valid/ready on both sides and frame-end handling.
module dequantizer_unpack
   import quant_pkg::*;
#(
   parameter int BITS     = 4,
   parameter bit MIDPOINT = 1'b1,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       in_word,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [5:0]        in_count,
   output logic [31:0]       out_sample,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              err,
   output logic [CNT_W-1:0]  sample_cnt
);

   localparam int         CPW  = cpw(BITS);
   localparam logic [5:0] CPW6 = 6'(CPW);

   generate
      if (!bits_legal(BITS)) begin : g_bad_bits
         $error("dequantizer_unpack: BITS must be one of 1, 2, 4, 8, 16");
      end
   endgenerate

   drain_state_e      state_q, state_d;
   logic [31:0]       sh_q, sh_d;
   logic [5:0]        rem_q, rem_d;
   logic              lw_q, lw_d;
   logic              err_q, err_d;
   logic              rdy_q, rdy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              in_xfer;
   logic              out_xfer;
   logic              bad_count;
   logic [31:0]       recon_sample;

   dequant_recon #(
      .BITS     (BITS),
      .MIDPOINT (MIDPOINT)
   ) u_recon (
      .code   (sh_q[31 -: BITS]),
      .sample (recon_sample)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         sh_q    <= '0;
         rem_q   <= '0;
         lw_q    <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         rem_q   <= rem_d;
         lw_q    <= lw_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      rem_d   = rem_q;
      lw_d    = lw_q;
      cnt_d   = cnt_q;
      rdy_d   = 1'b1;

      out_valid  = (state_q == DRAIN);
      out_last   = (state_q == DRAIN) && lw_q && (rem_q == 6'd1);
      out_sample = (state_q == DRAIN) ? recon_sample : 32'd0;
      // rdy_q keeps in_ready low until the first edge after reset release.
      in_ready   = rdy_q && ((state_q == EMPTY) || ((rem_q == 6'd1) && out_ready));

      in_xfer   = in_valid && in_ready;
      out_xfer  = out_valid && out_ready;
      bad_count = in_last && ((in_count == 6'd0) || (in_count > CPW6));
      err_d     = in_xfer && bad_count;

      if (out_xfer) begin
         sh_d  = sh_q << BITS;
         rem_d = rem_q - 6'd1;
         if (out_last) begin
            cnt_d = '0;
         end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      // A fresh word overrides the shift of the final code of the previous one.
      if (in_xfer) begin
         sh_d  = in_word;
         rem_d = (in_last && !bad_count) ? in_count : CPW6;
         lw_d  = in_last;
      end

      state_d = (rem_d != 6'd0) ? DRAIN : EMPTY;
   end

   assign err        = err_q;
   assign sample_cnt = cnt_q;

endmodule
